// File: rtl/demultiplexor_1a2_8bits_pkg.sv
// demultiplexor_1a2_8bits_pkg: port-select encodings and default sizing for the 1:2 stream demultiplexer
package demultiplexor_1a2_8bits_pkg;
    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;
    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_DEPTH = 2;
    localparam int   DEF_CNTW  = 16;
endpackage

// File: rtl/buffer_salida_fifo.sv
// buffer_salida_fifo: synchronous FIFO with registered head; push while full and pop while empty are ignored
module buffer_salida_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ONE = AW'(1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic do_push, do_pop;
    assign full    = occ == (AW+1)'(DEPTH);
    assign empty   = occ == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    // power-of-2 depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + ONE;
            occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/demultiplexor_1a2_8bits.sv
// demultiplexor_1a2_8bits: steers one valid/ready byte stream to port A or B, each with its own buffer
module demultiplexor_1a2_8bits
    import demultiplexor_1a2_8bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNTW-1:0]  cnt_a,
    output logic [CNTW-1:0]  cnt_b
);
    logic full_a, full_b, empty_a, empty_b;
    logic accept, push_a, push_b, pop_a, pop_b;
    // a full port stalls its own bytes even when it pops this cycle
    assign in_ready = ~rst & ~(sel == SEL_B ? full_b : full_a);
    assign accept   = in_valid & in_ready;
    assign push_a   = accept & (sel == SEL_A);
    assign push_b   = accept & (sel == SEL_B);
    assign a_valid  = ~empty_a;
    assign b_valid  = ~empty_b;
    assign pop_a    = a_valid & a_ready;
    assign pop_b    = b_valid & b_ready;
    buffer_salida_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .data(in_data),
        .full(full_a), .empty(empty_a), .head(a_data)
    );
    buffer_salida_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .data(in_data),
        .full(full_b), .empty(empty_b), .head(b_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            cnt_a <= cnt_a + CNTW'(pop_a);
            cnt_b <= cnt_b + CNTW'(pop_b);
        end
    end
endmodule

// File: tb/tb_demultiplexor_1a2_8bits.sv
// tb_demultiplexor_1a2_8bits: vector table plus queue scoreboard for the 1:2 byte demultiplexer
module tb_demultiplexor_1a2_8bits;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, sel, a_valid, a_ready, b_valid, b_ready;
    logic [7:0] in_data, a_data, b_data;
    logic [15:0] cnt_a, cnt_b;
    logic [15:0] exp_cnt_a = '0, exp_cnt_b = '0;
    logic [7:0] qa[$], qb[$];
    logic mon_en = 1'b0;
    logic exp_ir;
    int tests = 0, fails = 0;

    typedef struct {
        logic v, s;
        logic [7:0] d;
        logic ar, br, ea_v;
        logic [7:0] ea_d;
        logic eb_v;
        logic [7:0] eb_d;
        logic eir;
    } vec_t;
    vec_t tbl[11];

    demultiplexor_1a2_8bits dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: state seen at the negedge is what the next rising edge acts on
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
            chk("sb_b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
            if (a_valid && qa.size() != 0) chk("sb_a_data", {24'b0, a_data}, {24'b0, qa[0]});
            if (b_valid && qb.size() != 0) chk("sb_b_data", {24'b0, b_data}, {24'b0, qb[0]});
            chk("sb_cnt_a", {16'b0, cnt_a}, {16'b0, exp_cnt_a});
            chk("sb_cnt_b", {16'b0, cnt_b}, {16'b0, exp_cnt_b});
            exp_ir = !rst && (sel ? qb.size() < 2 : qa.size() < 2);
            chk("sb_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            if (rst) begin
                qa.delete();
                qb.delete();
                exp_cnt_a = '0;
                exp_cnt_b = '0;
            end else begin
                if (a_ready && qa.size() != 0) begin void'(qa.pop_front()); exp_cnt_a++; end
                if (b_ready && qb.size() != 0) begin void'(qb.pop_front()); exp_cnt_b++; end
                if (in_valid && exp_ir) begin
                    if (sel) qb.push_back(in_data);
                    else qa.push_back(in_data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic ar, input logic br);
        @(posedge clk);
        #1;
        in_valid = v; sel = s; in_data = d; a_ready = ar; b_ready = br;
    endtask

    initial begin
        //            v  s  d      ar br av ad     bv bd     ir
        tbl[0]  = '{1, 0, 8'h11, 1, 1, 0, 8'h00, 0, 8'h00, 1};
        tbl[1]  = '{1, 1, 8'h22, 1, 1, 1, 8'h11, 0, 8'h00, 1};
        tbl[2]  = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 8'h22, 1};
        tbl[3]  = '{1, 0, 8'h01, 0, 1, 0, 8'h00, 0, 8'h00, 1};
        tbl[4]  = '{1, 0, 8'h02, 0, 1, 1, 8'h01, 0, 8'h00, 1};
        tbl[5]  = '{1, 0, 8'h03, 0, 1, 1, 8'h01, 0, 8'h00, 0};
        tbl[6]  = '{1, 1, 8'h44, 0, 0, 1, 8'h01, 0, 8'h00, 1};
        tbl[7]  = '{1, 0, 8'h03, 1, 0, 1, 8'h01, 1, 8'h44, 0};
        tbl[8]  = '{1, 0, 8'h03, 1, 0, 1, 8'h02, 1, 8'h44, 1};
        tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 8'h03, 1, 8'h44, 1};
        tbl[10] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 1};
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("rst_a_data", {24'b0, a_data}, 32'd0);
        chk("rst_b_data", {24'b0, b_data}, 32'd0);
        chk("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
        chk("rst_cnt_b", {16'b0, cnt_b}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d_a_valid", i), {31'b0, a_valid}, {31'b0, tbl[i].ea_v});
            chk($sformatf("vec%0d_b_valid", i), {31'b0, b_valid}, {31'b0, tbl[i].eb_v});
            if (tbl[i].ea_v) chk($sformatf("vec%0d_a_data", i), {24'b0, a_data}, {24'b0, tbl[i].ea_d});
            if (tbl[i].eb_v) chk($sformatf("vec%0d_b_data", i), {24'b0, b_data}, {24'b0, tbl[i].eb_d});
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].eir});
        end
        drive(0, 0, 8'h00, 1, 1);
        @(negedge clk);
        chk("table_cnt_a", {16'b0, cnt_a}, 32'd4);
        chk("table_cnt_b", {16'b0, cnt_b}, 32'd2);
        // mid-stream reset with bytes parked in both buffers
        drive(1, 0, 8'h55, 0, 0);
        drive(1, 0, 8'h66, 0, 0);
        drive(1, 1, 8'h77, 0, 0);
        drive(1, 0, 8'h88, 1, 1);
        rst = 1'b1;
        drive(0, 0, 8'h00, 1, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_a_valid", {31'b0, a_valid}, 32'd0);
        chk("midrst_b_valid", {31'b0, b_valid}, 32'd0);
        chk("midrst_cnt_a", {16'b0, cnt_a}, 32'd0);
        chk("midrst_cnt_b", {16'b0, cnt_b}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 1, 1);
            @(negedge clk);
            chk("no_stale_a", {31'b0, a_valid}, 32'd0);
            chk("no_stale_b", {31'b0, b_valid}, 32'd0);
        end
        // 65536 pops on B wrap the counter back to zero
        for (int i = 0; i < 65536; i++) drive(1, 1, 8'(i), 1, 1);
        drive(0, 1, 8'h00, 1, 1);
        @(negedge clk);
        chk("wrap_cnt_b_max", {16'b0, cnt_b}, 32'd65535);
        drive(0, 1, 8'h00, 1, 1);
        @(negedge clk);
        chk("wrap_cnt_b_zero", {16'b0, cnt_b}, 32'd0);
        chk("wrap_b_valid", {31'b0, b_valid}, 32'd0);
        chk("wrap_cnt_a", {16'b0, cnt_a}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
